// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO with storage, occupancy count, programmable thresholds,
// sticky error flags, synchronous flush and optional first-word-fall-through read.
module fifo_ctrl_param #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_BITS  = 7,
  parameter int FWFT       = 0,
  parameter int SYNC_RESET = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [FIFO_BITS:0]    af_level,
  input  logic [FIFO_BITS:0]    ae_level,
  input  logic                  clr_err,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [FIFO_BITS:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** FIFO_BITS;
  localparam logic [FIFO_BITS:0] CNT_FULL = {1'b1, {FIFO_BITS{1'b0}}};
  localparam logic [FIFO_BITS:0] CNT_ONE  = {{FIFO_BITS{1'b0}}, 1'b1};
  localparam logic [FIFO_BITS-1:0] PTR_ONE = {{(FIFO_BITS-1){1'b0}}, 1'b1};

  // All resettable control state lives in one struct so both reset styles share one next-state path.
  typedef struct packed {
    logic [FIFO_BITS-1:0]  wr_ptr;
    logic [FIFO_BITS-1:0]  rd_ptr;
    logic [FIFO_BITS:0]    cnt;
    logic [FIFO_WIDTH-1:0] dout;
    logic                  ovf;
    logic                  unf;
  } ctrl_t;

  ctrl_t                 cur;
  ctrl_t                 nxt;
  logic [FIFO_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_WIDTH-1:0] head_word;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_en;

  assign full      = (cur.cnt == CNT_FULL);
  assign empty     = (cur.cnt == '0);
  assign afull     = (cur.cnt >= af_level);
  assign aempty    = (cur.cnt <= ae_level);
  assign count     = cur.cnt;
  assign overflow  = cur.ovf;
  assign underflow = cur.unf;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  assign rd_acc    = !read_n && !empty;
  assign wr_acc    = !write_n && (!full || rd_acc);
  assign wr_en     = wr_acc && !flush && reset_n;
  assign head_word = mem[cur.rd_ptr];

  always_comb begin
    nxt = cur;
    if (flush) begin
      nxt = '0;
    end else begin
      if (wr_acc) nxt.wr_ptr = cur.wr_ptr + PTR_ONE;
      if (rd_acc) begin
        nxt.rd_ptr = cur.rd_ptr + PTR_ONE;
        if (FWFT == 0) nxt.dout = head_word;
      end
      if (wr_acc && !rd_acc) nxt.cnt = cur.cnt + CNT_ONE;
      else if (rd_acc && !wr_acc) nxt.cnt = cur.cnt - CNT_ONE;
      // A new error in the same cycle as clr_err keeps the flag set.
      if (!write_n && !wr_acc) nxt.ovf = 1'b1;
      else if (clr_err) nxt.ovf = 1'b0;
      if (!read_n && !rd_acc) nxt.unf = 1'b1;
      else if (clr_err) nxt.unf = 1'b0;
    end
  end

  generate
    if (SYNC_RESET != 0) begin : g_sync_rst
      always_ff @(posedge clock) begin
        if (!reset_n) cur <= '0;
        else          cur <= nxt;
      end
    end else begin : g_async_rst
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cur <= '0;
        else          cur <= nxt;
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (wr_en) mem[cur.wr_ptr] <= data_in;
  end

  // In FWFT mode the head word is shown directly and forced to zero while empty.
  assign data_out = (FWFT != 0) ? (empty ? '0 : head_word) : cur.dout;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Randomised scoreboard bench for fifo_ctrl_param: a queue-based reference model predicts
// every post-edge output of a registered-read and a FWFT instance driven by the same stimulus.
module tb_fifo_ctrl_param;

  localparam int W     = 8;
  localparam int B     = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [B:0]   cnt;
    logic         full;
    logic         empty;
    logic         afull;
    logic         aempty;
    logic         ovf;
    logic         unf;
    logic [W-1:0] dout;
    logic [W-1:0] dout_fw;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         write_n;
  logic         read_n;
  logic         clr_err;
  logic [W-1:0] data_in;
  logic [B:0]   af_level;
  logic [B:0]   ae_level;

  logic [W-1:0] data_out, data_out_fw;
  logic         full, empty, afull, aempty, overflow, underflow;
  logic         full_fw, empty_fw, afull_fw, aempty_fw, overflow_fw, underflow_fw;
  logic [B:0]   count, count_fw;

  logic [W-1:0] model_q[$];
  logic [W-1:0] m_dout;
  logic         m_ovf;
  logic         m_unf;
  logic [B:0]   tb_af;
  logic [B:0]   tb_ae;
  exp_t         exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fifo_ctrl_param #(.FIFO_WIDTH(W), .FIFO_BITS(B), .FWFT(0), .SYNC_RESET(0)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .data_in(data_in),
    .write_n(write_n), .read_n(read_n), .af_level(af_level), .ae_level(ae_level),
    .clr_err(clr_err), .data_out(data_out), .full(full), .empty(empty),
    .afull(afull), .aempty(aempty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  fifo_ctrl_param #(.FIFO_WIDTH(W), .FIFO_BITS(B), .FWFT(1), .SYNC_RESET(0)) dut_fw (
    .clock(clock), .reset_n(reset_n), .flush(flush), .data_in(data_in),
    .write_n(write_n), .read_n(read_n), .af_level(af_level), .ae_level(ae_level),
    .clr_err(clr_err), .data_out(data_out_fw), .full(full_fw), .empty(empty_fw),
    .afull(afull_fw), .aempty(aempty_fw), .count(count_fw), .overflow(overflow_fw),
    .underflow(underflow_fw)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and queues the model's post-edge view.
  task automatic apply_stimulus(input logic rn, input logic wn, input logic rdn,
                                input logic [W-1:0] d, input logic fl, input logic ce);
    exp_t e;
    bit   rd_ok;
    bit   wr_ok;
    bit   was_full;
    bit   was_empty;
    @(negedge clock);
    reset_n  = rn;
    write_n  = wn;
    read_n   = rdn;
    data_in  = d;
    flush    = fl;
    clr_err  = ce;
    af_level = tb_af;
    ae_level = tb_ae;
    if (!rn || fl) begin
      model_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      rd_ok = !rdn && !was_empty;
      wr_ok = !wn && (!was_full || rd_ok);
      if (rd_ok) m_dout = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
      m_ovf = (!wn && !wr_ok) ? 1'b1 : (ce ? 1'b0 : m_ovf);
      m_unf = (!rdn && !rd_ok) ? 1'b1 : (ce ? 1'b0 : m_unf);
    end
    e.cnt     = (B+1)'(model_q.size());
    e.full    = (model_q.size() == DEPTH);
    e.empty   = (model_q.size() == 0);
    e.afull   = (model_q.size() >= int'(tb_af));
    e.aempty  = (model_q.size() <= int'(tb_ae));
    e.ovf     = m_ovf;
    e.unf     = m_unf;
    e.dout    = m_dout;
    e.dout_fw = (model_q.size() != 0) ? model_q[0] : '0;
    exp_q.push_back(e);
  endtask

  // Monitor: after every active edge, compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output("count",       32'(count),       32'(e.cnt));
        check_output("full",        32'(full),        32'(e.full));
        check_output("empty",       32'(empty),       32'(e.empty));
        check_output("afull",       32'(afull),       32'(e.afull));
        check_output("aempty",      32'(aempty),      32'(e.aempty));
        check_output("overflow",    32'(overflow),    32'(e.ovf));
        check_output("underflow",   32'(underflow),   32'(e.unf));
        check_output("data_out",    32'(data_out),    32'(e.dout));
        check_output("fwft_data",   32'(data_out_fw), 32'(e.dout_fw));
        check_output("fwft_count",  32'(count_fw),    32'(e.cnt));
        check_output("fwft_ovf",    32'(overflow_fw), 32'(e.ovf));
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    flush    = 1'b0;
    write_n  = 1'b1;
    read_n   = 1'b1;
    clr_err  = 1'b0;
    data_in  = '0;
    m_dout   = '0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    tb_af    = 5'd12;
    tb_ae    = 5'd3;
    af_level = tb_af;
    ae_level = tb_ae;

    repeat (3) apply_stimulus(0, 1, 1, 8'h00, 0, 0);
    apply_stimulus(1, 1, 1, 8'h00, 0, 0);

    // Fill to full, then overflow attempt and clear
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1, 0, 1, W'(i), 0, 0);
    apply_stimulus(1, 0, 1, 8'hAA, 0, 0);
    apply_stimulus(1, 1, 1, 8'h00, 0, 1);
    // Simultaneous read+write at full
    apply_stimulus(1, 0, 0, 8'h55, 0, 0);
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1, 1, 0, 8'h00, 0, 0);
    // Underflow, then clr_err with a fresh underflow, then clear
    apply_stimulus(1, 1, 0, 8'h00, 0, 0);
    apply_stimulus(1, 1, 0, 8'h00, 0, 1);
    apply_stimulus(1, 1, 1, 8'h00, 0, 1);
    // Simultaneous read+write at empty
    apply_stimulus(1, 0, 0, 8'h33, 0, 0);
    apply_stimulus(1, 1, 0, 8'h00, 0, 0);
    apply_stimulus(1, 1, 1, 8'h00, 0, 1);

    // Thresholds reprogrammed mid-stream
    for (int i = 0; i < 8; i++) begin
      if (i == 3) tb_af = 5'd5;
      apply_stimulus(1, 0, 1, W'(8'hC0 + i), 0, 0);
    end
    for (int i = 0; i < 8; i++) apply_stimulus(1, 1, 0, 8'h00, 0, 0);
    tb_af = 5'd12;

    // Wrap-around passes
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 1, W'(p * 16 + i), 0, 0);
      for (int i = 0; i < 10; i++) apply_stimulus(1, 1, 0, 8'h00, 0, 0);
    end

    // Randomised traffic with occasional flush, clr_err, reset and threshold changes
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) begin
        tb_af = 5'($urandom_range(0, DEPTH));
        tb_ae = 5'($urandom_range(0, DEPTH));
      end
      apply_stimulus($urandom_range(0, 199) != 0,
                     (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                     (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                     W'($urandom), $urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0);
    end

    // Mid-burst reset and flush, then a write into an empty FWFT FIFO
    tb_af = 5'd12;
    tb_ae = 5'd3;
    apply_stimulus(1, 1, 1, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 1, W'(8'h10 + i), 0, 0);
    apply_stimulus(0, 0, 1, 8'hEE, 0, 0);
    apply_stimulus(1, 1, 1, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 1, W'(8'h20 + i), 0, 0);
    apply_stimulus(1, 0, 1, 8'hEF, 1, 0);
    apply_stimulus(1, 0, 1, 8'h7E, 0, 0);
    apply_stimulus(1, 1, 1, 8'h00, 0, 0);
    apply_stimulus(1, 1, 0, 8'h00, 0, 0);
    apply_stimulus(1, 1, 1, 8'h00, 0, 0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
